cpu_step_ctrl: RTL
==================

# cpu_step_ctrl

Run/step/breakpoint sequencer for the single-cycle RISC-V core. It runs on the board clock and produces a one-cycle clock-enable `cpu_ce` that advances the CPU by exactly one instruction per pulse. It replaces the free-running divided CPU clock with four behaviours: free run at two speeds, debounced single-step, PC breakpoint, and halt on a decoded halt instruction. It sits between the board switches/buttons and the PC/RF/DM write enables. It also exports a retired-instruction count for the 7-segment display mux.

## Interface
- `DIV_FAST`, default 2**25: board clocks per instruction in fast run.
- `DIV_SLOW`, default 2**27: board clocks per instruction in slow run.
- `DEB_CYCLES`, default 1_000_000: stable cycles required to accept a button level change.
- `PC_W`, default 5: width of the instruction-ROM word address.

Ports (reset rstn, asynchronous, active-low; clock clk):
- `clk` in 1: board clock.
- `rstn` in 1: async active-low reset.
- `run_sw` in 1: level; 1 = run, 0 = pause. Synchronous to clk.
- `slow_sw` in 1: 1 selects `DIV_SLOW`, 0 selects `DIV_FAST`.
- `step_btn` in 1: raw asynchronous push-button, active-high.
- `bp_en` in 1: breakpoint enable.
- `bp_addr` in PC_W: breakpoint word address.
- `pc` in PC_W: current instruction word address (ROM address register).
- `halt_instr` in 1: current instruction decodes as halt (ebreak/ecall).
- `cpu_ce` out 1: one-clk advance pulse; gates every CPU state update.
- `state_o` out 2: 0 PAUSE, 1 RUN, 2 STEP, 3 HALT.
- `halted` out 1: state == HALT.
- `retired` out 32: count of issued `cpu_ce` pulses.

## Operation
- Button path: 2-flop synchronizer, then a debouncer. The debounced level follows the synced level only after DEB_CYCLES consecutive equal samples. A rising edge of the debounced level gives a one-cycle `press`.
- States and transitions:
  - PAUSE:
    - If `run_sw` = 1, go to RUN, clear the divider, set `bp_skip` = 1.
    - Else if `press` and `halt_instr`, go to HALT.
    - Else if `press`, go to STEP.
  - STEP: `cpu_ce` = 1 for this cycle. Increment `retired`. Unconditionally go to PAUSE.
  - RUN:
    - If `run_sw` = 0, go to PAUSE and clear the divider.
    - Otherwise the divider increments each cycle. A tick occurs when divider ≥ target−1 (target = `DIV_SLOW` if `slow_sw` else `DIV_FAST`); on a tick the divider resets to 0.
    - On a tick, in priority order:
      1. `halt_instr` → HALT, no ce.
      2. `bp_en` && `pc` == `bp_addr` && !`bp_skip` → PAUSE, no ce.
      3. Otherwise issue ce, increment `retired`, clear `bp_skip`.
  - HALT: sticky. No ce is ever issued. Left only by reset.
- `press` in RUN, STEP or HALT is discarded (not queued).
- A breakpoint hit while `bp_skip` is set is ignored, so resuming from a breakpoint advances past it. A single step from PAUSE ignores the breakpoint entirely.
- `retired` saturates at 32'hFFFF_FFFF.
- `run_sw` and `press` in the same PAUSE cycle: `run_sw` wins and the press is dropped.

## Timing
- Reset values: state PAUSE, `cpu_ce` 0, `halted` 0, `state_o` 0, `retired` 0, divider 0, `bp_skip` 0, debounced level 0.
- All outputs are registered.
- `cpu_ce` is never high in two consecutive cycles and never high in PAUSE or HALT.
- Step latency: a `press` seen in PAUSE in cycle N gives state STEP with `cpu_ce` = 1 in cycle N+1, and PAUSE in cycle N+2.
- Run period: exactly target clocks between ce pulses in steady state. The first ce comes target cycles after entering RUN.
- Speed change mid-count: the new target applies immediately. If the divider is already ≥ new target−1, the tick occurs next cycle.
- Reset mid-operation aborts at once. A ce in flight is dropped, and `retired` clears.
- `pc`/`halt_instr` are sampled in the tick cycle and must reflect the instruction that ce would retire.

## Structure
- Package `cpu_ctrl_pkg`: state encoding constants (PAUSE/RUN/STEP/HALT), `PC_W` default, DIV/DEB defaults.
- Sub-module `btn_debounce` (synchronizer + stability counter + rising-edge pulse), parameterized by DEB_CYCLES.
- Top level: FSM, divider, breakpoint compare, retired counter.

## Test plan
All scenarios use DIV_FAST=4, DIV_SLOW=8, DEB_CYCLES=3.
- Reset, then `run_sw`=1, `slow_sw`=0, `bp_en`=0 for 20 cycles → ce pulses every 4 cycles, first at cycle 4; `retired`=5; `state_o`=1.
- Reset, then `step_btn` held high 10 cycles → exactly one ce, 1 cycle after `press`; `retired`=1; back to PAUSE. A 2-cycle glitch produces no ce.
- `bp_en`=1, `bp_addr`=3, `pc` incremented on each ce from 0 → ce issued for pc 0,1,2; PAUSE at pc=3 with `retired`=3. Toggling `run_sw` 0→1 → ce at pc=3, then it continues.
- RUN with `halt_instr` asserted at the 2nd tick → `retired`=1, `halted`=1, `state_o`=3. Subsequent step presses and `run_sw` toggles → no ce until reset.
- RUN with divider at 6, `slow_sw`=1 switched to 0 → tick next cycle, then a period of 4.
- Reset asserted in the STEP cycle → `cpu_ce` 0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and default parameters for the CPU run/step sequencer.
// State codes are visible to software through state_o, so they are fixed.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_HALT  = 2'd3
    } ctrl_state_t;

    localparam int PC_W_DEF       = 5;
    localparam int DIV_FAST_DEF   = 2**25;
    localparam int DIV_SLOW_DEF   = 2**27;
    localparam int DEB_CYCLES_DEF = 1_000_000;
    localparam int SYNC_STAGES    = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_debounce.sv
// Push-button conditioning: two-flop synchronizer, stability counter and
// a one-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce
    import cpu_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   deb_reg, deb_next;
    logic                   press_reg;
    logic                   synced;

    assign synced = sync_reg[SYNC_STAGES-1];

    // The counter only runs while the synced level disagrees with the
    // accepted level; any agreeing sample restarts the stability window.
    always_comb begin
        cnt_next = cnt_reg;
        deb_next = deb_reg;
        if (synced == deb_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
            deb_next = synced;
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            deb_reg   <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], btn};
            cnt_reg   <= cnt_next;
            deb_reg   <= deb_next;
            press_reg <= deb_next & ~deb_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step/breakpoint sequencer producing the single-cycle CPU clock enable
// and a saturating retired-instruction count.
module cpu_step_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DIV_FAST   = DIV_FAST_DEF,
    parameter int DIV_SLOW   = DIV_SLOW_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int PC_W       = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            run_sw,
    input  logic            slow_sw,
    input  logic            step_btn,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic [PC_W-1:0] pc,
    input  logic            halt_instr,
    output logic            cpu_ce,
    output logic [1:0]      state_o,
    output logic            halted,
    output logic [31:0]     retired
);

    localparam int DIV_W = $clog2(max_int(DIV_FAST, DIV_SLOW) + 1);

    ctrl_state_t      state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next, target_m1;
    logic             skip_reg, skip_next;
    logic             ce_reg, ce_next;
    logic             halted_reg;
    logic [31:0]      retired_reg;
    logic             press, tick, bp_hit;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn (
        .clk  (clk),
        .rstn (rstn),
        .btn  (step_btn),
        .press(press)
    );

    // Target follows slow_sw combinationally so a speed change takes effect
    // on the very next compare.
    assign target_m1 = slow_sw ? DIV_W'(DIV_SLOW - 1) : DIV_W'(DIV_FAST - 1);
    assign tick      = (div_reg >= target_m1);
    assign bp_hit    = bp_en && (pc == bp_addr) && !skip_reg;

    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        skip_next  = skip_reg;
        ce_next    = 1'b0;
        case (state_reg)
            ST_PAUSE: begin
                if (run_sw) begin
                    state_next = ST_RUN;
                    div_next   = '0;
                    skip_next  = 1'b1;
                end else if (press) begin
                    state_next = halt_instr ? ST_HALT : ST_STEP;
                end
            end
            ST_STEP: state_next = ST_PAUSE;
            ST_RUN: begin
                if (!run_sw) begin
                    state_next = ST_PAUSE;
                    div_next   = '0;
                end else if (tick) begin
                    div_next = '0;
                    if (halt_instr) begin
                        state_next = ST_HALT;
                    end else if (bp_hit) begin
                        state_next = ST_PAUSE;
                    end else begin
                        ce_next   = 1'b1;
                        skip_next = 1'b0;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_PAUSE;
        endcase
        if (state_next == ST_STEP) begin
            ce_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= ST_PAUSE;
            div_reg     <= '0;
            skip_reg    <= 1'b0;
            ce_reg      <= 1'b0;
            halted_reg  <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= div_next;
            skip_reg   <= skip_next;
            ce_reg     <= ce_next;
            halted_reg <= (state_next == ST_HALT);
            if (ce_next && (retired_reg != 32'hFFFF_FFFF)) begin
                retired_reg <= retired_reg + 32'd1;
            end
        end
    end

    assign cpu_ce  = ce_reg;
    assign state_o = state_reg;
    assign halted  = halted_reg;
    assign retired = retired_reg;

endmodule
